// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - Registered, handshaked Beta opcode decode stage
// Decodes one opcode per accepted beat; traps illegal opcodes and IRQs; holds for MUL/DIV.
module ctrl_decode_stage #(
   parameter int OPC_W      = 6,
   parameter int ALUFN_W    = 6,
   parameter int PCSEL_W    = 3,
   parameter int MULDIV_LAT = 4,
   parameter int IRQ_EN     = 1
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [OPC_W-1:0]   OPCODE,
   input  logic               SUPERVISOR,
   input  logic               IRQ,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [PCSEL_W-1:0] PCSEL,
   output logic               BR_NE,
   output logic               RA2SEL,
   output logic               ASEL,
   output logic               BSEL,
   output logic [1:0]         WDSEL,
   output logic [ALUFN_W-1:0] ALUFN,
   output logic               WR,
   output logic               WERF,
   output logic               WASEL,
   output logic               TRAP,
   output logic               BUSY
);

   localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_MULTI} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

   logic [PCSEL_W-1:0]  r_pcsel, w_pcsel;
   logic [ALUFN_W-1:0]  r_alufn, w_alufn;
   logic [1:0]          r_wdsel, w_wdsel;
   logic                r_br_ne, w_br_ne;
   logic                r_ra2sel, w_ra2sel;
   logic                r_asel, w_asel;
   logic                r_bsel, w_bsel;
   logic                r_wr, w_wr;
   logic                r_werf, w_werf;
   logic                r_wasel, w_wasel;
   logic                r_trap, w_trap;

   logic [5:0]          w_op;
   logic                w_hi_zero;
   logic                w_illegal;
   logic                w_muldiv;
   logic                w_irq_take;
   logic                w_out_valid;
   logic                w_in_ready;
   logic                w_accept;

   assign w_op        = OPCODE[5:0];
   assign w_hi_zero   = ((OPCODE >> 6) == '0);
   assign w_irq_take  = (IRQ_EN != 0) & IRQ & ~SUPERVISOR;
   assign w_out_valid = (r_state == ST_VALID);
   assign w_in_ready  = RESET_N & (r_state != ST_MULTI) & (~w_out_valid | OUT_READY);
   assign w_accept    = IN_VALID & w_in_ready;

   always_comb begin
      w_pcsel   = '0;
      w_br_ne   = 1'b0;
      w_ra2sel  = 1'b0;
      w_asel    = 1'b0;
      w_bsel    = 1'b0;
      w_wdsel   = 2'd0;
      w_alufn   = '0;
      w_wr      = 1'b0;
      w_werf    = 1'b0;
      w_wasel   = 1'b0;
      w_trap    = 1'b0;
      w_illegal = 1'b0;
      w_muldiv  = 1'b0;
      if (!w_hi_zero) begin
         w_illegal = 1'b1;
      end else if (w_op[5]) begin
         // ALU and ALUC share the function field; OPCODE[4] selects the literal
         w_wdsel = 2'd1;
         w_werf  = 1'b1;
         w_bsel  = w_op[4];
         case (w_op[3:0])
            4'h0: w_alufn = ALUFN_W'(6'h00);
            4'h1: w_alufn = ALUFN_W'(6'h01);
            4'h2: begin w_alufn = ALUFN_W'(6'h02); w_muldiv = 1'b1; end
            4'h3: begin w_alufn = ALUFN_W'(6'h03); w_muldiv = 1'b1; end
            4'h4: w_alufn = ALUFN_W'(6'h33);
            4'h5: w_alufn = ALUFN_W'(6'h35);
            4'h6: w_alufn = ALUFN_W'(6'h37);
            4'h8: w_alufn = ALUFN_W'(6'h18);
            4'h9: w_alufn = ALUFN_W'(6'h1E);
            4'hA: w_alufn = ALUFN_W'(6'h16);
            4'hC: w_alufn = ALUFN_W'(6'h20);
            4'hD: w_alufn = ALUFN_W'(6'h21);
            4'hE: w_alufn = ALUFN_W'(6'h23);
            default: w_illegal = 1'b1;
         endcase
      end else begin
         case (w_op)
            6'h18: begin w_bsel = 1'b1; w_wdsel = 2'd2; w_werf = 1'b1; end
            6'h19: begin w_bsel = 1'b1; w_ra2sel = 1'b1; w_wr = 1'b1; end
            6'h1B: begin w_pcsel = PCSEL_W'(2); w_werf = 1'b1; end
            6'h1D: begin w_pcsel = PCSEL_W'(1); w_werf = 1'b1; end
            6'h1E: begin w_pcsel = PCSEL_W'(1); w_br_ne = 1'b1; w_werf = 1'b1; end
            6'h1F: begin w_asel = 1'b1; w_alufn = ALUFN_W'(6'h1A); w_wdsel = 2'd2; w_werf = 1'b1; end
            default: w_illegal = 1'b1;
         endcase
      end
      if (w_irq_take || w_illegal) begin
         w_pcsel  = w_irq_take ? PCSEL_W'(4) : PCSEL_W'(3);
         w_br_ne  = 1'b0;
         w_ra2sel = 1'b0;
         w_asel   = 1'b0;
         w_bsel   = 1'b0;
         w_wdsel  = 2'd0;
         w_alufn  = '0;
         w_wr     = 1'b0;
         w_werf   = 1'b1;
         w_wasel  = 1'b1;
         w_trap   = 1'b1;
         w_muldiv = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_MULTI: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_nxt = ST_VALID;
         end
         default: begin
            if (w_accept) begin
               if (w_muldiv && (MULDIV_LAT > 1)) begin
                  w_state_nxt = ST_MULTI;
                  w_cnt_nxt   = CNT_W'(MULDIV_LAT - 1);
               end else begin
                  w_state_nxt = ST_VALID;
               end
            end else if (r_state == ST_VALID && OUT_READY) begin
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_pcsel  <= '0;
         r_br_ne  <= 1'b0;
         r_ra2sel <= 1'b0;
         r_asel   <= 1'b0;
         r_bsel   <= 1'b0;
         r_wdsel  <= 2'd0;
         r_alufn  <= '0;
         r_wr     <= 1'b0;
         r_werf   <= 1'b0;
         r_wasel  <= 1'b0;
         r_trap   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_pcsel  <= w_pcsel;
            r_br_ne  <= w_br_ne;
            r_ra2sel <= w_ra2sel;
            r_asel   <= w_asel;
            r_bsel   <= w_bsel;
            r_wdsel  <= w_wdsel;
            r_alufn  <= w_alufn;
            r_wr     <= w_wr;
            r_werf   <= w_werf;
            r_wasel  <= w_wasel;
            r_trap   <= w_trap;
         end
      end
   end

   // Side-effecting controls are masked so an idle or busy stage never writes
   assign IN_READY  = w_in_ready;
   assign OUT_VALID = w_out_valid;
   assign BUSY      = (r_state == ST_MULTI);
   assign PCSEL     = r_pcsel;
   assign BR_NE     = r_br_ne;
   assign RA2SEL    = r_ra2sel;
   assign ASEL      = r_asel;
   assign BSEL      = r_bsel;
   assign WDSEL     = r_wdsel;
   assign ALUFN     = r_alufn;
   assign WASEL     = r_wasel;
   assign WR        = r_wr & w_out_valid;
   assign WERF      = r_werf & w_out_valid;
   assign TRAP      = r_trap & w_out_valid;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - Self-checking bench for ctrl_decode_stage
// Directed scenarios plus randomized traffic against a table-driven decode model.
module tb_ctrl_decode_stage;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, supervisor, irq, out_valid, out_ready;
   logic [5:0] opcode;
   logic [2:0] pcsel;
   logic       br_ne, ra2sel, asel, bsel;
   logic [1:0] wdsel;
   logic [5:0] alufn;
   logic       wr, werf, wasel, trap, busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0] pcsel;
      logic       br_ne;
      logic       ra2sel;
      logic       asel;
      logic       bsel;
      logic [1:0] wdsel;
      logic [5:0] alufn;
      logic       wr;
      logic       werf;
      logic       wasel;
      logic       trap;
   } ctl_t;

   localparam logic [5:0] ALU_TAB [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h33, 6'h35, 6'h37, 6'h00,
                                           6'h18, 6'h1E, 6'h16, 6'h00, 6'h20, 6'h21, 6'h23, 6'h00};
   localparam logic [15:0] ALU_OK = 16'b0111_0111_0111_1111;
   localparam logic [5:0] MD_OPS [4] = '{6'h22, 6'h23, 6'h32, 6'h33};
   localparam logic [5:0] ILL_OPS [6] = '{6'h27, 6'h1C, 6'h00, 6'h3F, 6'h1A, 6'h17};

   ctrl_decode_stage #(
      .OPC_W(6), .ALUFN_W(6), .PCSEL_W(3), .MULDIV_LAT(LAT), .IRQ_EN(1)
   ) dut (
      .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .OPCODE(opcode),
      .SUPERVISOR(supervisor), .IRQ(irq), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .PCSEL(pcsel), .BR_NE(br_ne), .RA2SEL(ra2sel), .ASEL(asel), .BSEL(bsel), .WDSEL(wdsel),
      .ALUFN(alufn), .WR(wr), .WERF(werf), .WASEL(wasel), .TRAP(trap), .BUSY(busy)
   );

   always #5 clk = ~clk;

   function automatic ctl_t ref_ctl(input logic [5:0] op, input logic irq_i, input logic sup_i);
      ctl_t c;
      logic legal;
      c = '0;
      legal = 1'b1;
      if (op >= 6'h20) begin
         legal   = ALU_OK[op[3:0]];
         c.alufn = ALU_TAB[op[3:0]];
         c.bsel  = op[4];
         c.wdsel = 2'd1;
         c.werf  = 1'b1;
      end else if (op == 6'h18) begin
         c.bsel = 1'b1; c.wdsel = 2'd2; c.werf = 1'b1;
      end else if (op == 6'h19) begin
         c.bsel = 1'b1; c.ra2sel = 1'b1; c.wr = 1'b1;
      end else if (op == 6'h1B) begin
         c.pcsel = 3'd2; c.werf = 1'b1;
      end else if (op == 6'h1D || op == 6'h1E) begin
         c.pcsel = 3'd1; c.br_ne = (op == 6'h1E); c.werf = 1'b1;
      end else if (op == 6'h1F) begin
         c.asel = 1'b1; c.alufn = 6'h1A; c.wdsel = 2'd2; c.werf = 1'b1;
      end else begin
         legal = 1'b0;
      end
      if ((irq_i && !sup_i) || !legal) begin
         c       = '0;
         c.pcsel = (irq_i && !sup_i) ? 3'd4 : 3'd3;
         c.wasel = 1'b1;
         c.werf  = 1'b1;
         c.trap  = 1'b1;
      end
      return c;
   endfunction

   function automatic int ref_lat(input logic [5:0] op, input logic irq_i, input logic sup_i);
      if (irq_i && !sup_i) return 1;
      if (op == 6'h22 || op == 6'h23 || op == 6'h32 || op == 6'h33) return LAT;
      return 1;
   endfunction

   function automatic ctl_t dut_ctl();
      return ctl_t'({pcsel, br_ne, ra2sel, asel, bsel, wdsel, alufn, wr, werf, wasel, trap});
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, input logic i, input logic s, input logic r);
      @(negedge clk);
      in_valid   = v;
      opcode     = op;
      irq        = i;
      supervisor = s;
      out_ready  = r;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 6'h30, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 6'h30, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({in_ready, out_valid, busy, dut_ctl()} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0", {in_ready, out_valid, busy, dut_ctl()});
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_release: got rdy/vld/busy %b expected 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_addc();
      drive(1'b1, 6'h30, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, alufn, bsel, wdsel, werf, wr} !== {1'b1, 6'h00, 1'b1, 2'd1, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL addc_fields: got %h expected %h", {out_valid, alufn, bsel, wdsel, werf, wr},
                  {1'b1, 6'h00, 1'b1, 2'd1, 1'b1, 1'b0});
      end
      n_cmp++;
      if (dut_ctl() !== ref_ctl(6'h30, 1'b0, 1'b0)) begin
         n_bad++;
         $display("FAIL addc_ctl: got %h expected %h", dut_ctl(), ref_ctl(6'h30, 1'b0, 1'b0));
      end
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, werf} !== 2'b00) begin
         n_bad++;
         $display("FAIL addc_drain: got vld/werf %b expected 00", {out_valid, werf});
      end
   endtask

   task automatic test_muldiv();
      drive(1'b1, 6'h22, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < LAT - 1; k++) begin
         drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if ({busy, in_ready, out_valid, werf} !== 4'b1000) begin
            n_bad++;
            $display("FAIL muldiv_busy[%0d]: got busy/rdy/vld/werf %b expected 1000", k,
                     {busy, in_ready, out_valid, werf});
         end
      end
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, busy, alufn} !== {1'b1, 1'b0, 6'h02}) begin
         n_bad++;
         $display("FAIL muldiv_done: got vld/busy/alufn %h expected %h", {out_valid, busy, alufn},
                  {1'b1, 1'b0, 6'h02});
      end
      n_cmp++;
      if (dut_ctl() !== ref_ctl(6'h22, 1'b0, 1'b0)) begin
         n_bad++;
         $display("FAIL muldiv_ctl: got %h expected %h", dut_ctl(), ref_ctl(6'h22, 1'b0, 1'b0));
      end
   endtask

   task automatic test_illop();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, ILL_OPS[k], 1'b0, 1'b0, 1'b1);
         drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if ({out_valid, pcsel, wasel, wdsel, werf, trap, wr} !== {1'b1, 3'd3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL illop_%h: got %h expected %h", ILL_OPS[k],
                     {out_valid, pcsel, wasel, wdsel, werf, trap, wr},
                     {1'b1, 3'd3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0});
         end
      end
   endtask

   task automatic test_irq();
      drive(1'b1, 6'h19, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, pcsel, wr, werf, wasel, trap} !== {1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL irq_st: got %h expected %h", {out_valid, pcsel, wr, werf, wasel, trap},
                  {1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1});
      end
      drive(1'b1, 6'h19, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (dut_ctl() !== ref_ctl(6'h19, 1'b0, 1'b0) || wr !== 1'b1) begin
         n_bad++;
         $display("FAIL irq_masked_st: got %h expected %h", dut_ctl(), ref_ctl(6'h19, 1'b0, 1'b0));
      end
      drive(1'b1, 6'h22, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, busy, pcsel, trap} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
         n_bad++;
         $display("FAIL irq_mul: got vld/busy/pcsel/trap %h expected %h", {out_valid, busy, pcsel, trap},
                  {1'b1, 1'b0, 3'd4, 1'b1});
      end
   endtask

   task automatic test_backpressure();
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 6'h1E, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 6'h20, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({out_valid, in_ready, pcsel, br_ne} !== {1'b1, 1'b0, 3'd1, 1'b1} ||
             dut_ctl() !== ref_ctl(6'h1E, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL hold_bne[%0d]: got %h expected %h", k, dut_ctl(), ref_ctl(6'h1E, 1'b0, 1'b0));
         end
      end
      drive(1'b1, 6'h20, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL release_ready: got %b expected 1", in_ready);
      end
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || dut_ctl() !== ref_ctl(6'h20, 1'b0, 1'b0)) begin
         n_bad++;
         $display("FAIL after_hold: got %h expected %h", dut_ctl(), ref_ctl(6'h20, 1'b0, 1'b0));
      end
   endtask

   task automatic test_reset_mid_multi();
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 6'h23, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midmulti_busy: got %b expected 1", busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, busy, dut_ctl()} !== '0) begin
         n_bad++;
         $display("FAIL midmulti_reset: got %h expected 0", {in_ready, out_valid, busy, dut_ctl()});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL stale_beat[%0d]: got vld/busy/rdy %b expected 001", k, {out_valid, busy, in_ready});
         end
      end
   endtask

   task automatic test_random(input int n);
      ctl_t       exp_q[$];
      int         acc_q[$];
      int         lat_q[$];
      int         cyc;
      logic       presented;
      logic       v, i, s, r;
      logic [5:0] op;
      cyc = 0;
      presented = 1'b0;
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < n + 20; k++) begin
         if (k < n) begin
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 3) == 0) ? MD_OPS[$urandom_range(0, 3)] : 6'($urandom_range(0, 63));
            i  = ($urandom_range(0, 7) == 0);
            s  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
         end else begin
            v = 1'b0; op = 6'h00; i = 1'b0; s = 1'b0; r = 1'b1;
         end
         drive(v, op, i, s, r);
         n_cmp++;
         if (!out_valid && (wr || werf || trap)) begin
            n_bad++;
            $display("FAIL rand_bubble_write: got wr/werf/trap %b expected 000", {wr, werf, trap});
         end
         if (out_valid && !presented) begin
            presented = 1'b1;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL rand_extra_beat: got %h expected no beat", dut_ctl());
            end else begin
               if (cyc - acc_q[0] != lat_q[0] || dut_ctl() !== exp_q[0]) begin
                  n_bad++;
                  $display("FAIL rand_present: got ctl %h lat %0d expected ctl %h lat %0d",
                           dut_ctl(), cyc - acc_q[0], exp_q[0], lat_q[0]);
               end
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
               n_cmp++;
               if (dut_ctl() !== exp_q[0]) begin
                  n_bad++;
                  $display("FAIL rand_consume: got %h expected %h", dut_ctl(), exp_q[0]);
               end
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
               void'(lat_q.pop_front());
            end
            presented = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_ctl(op, i, s));
            acc_q.push_back(cyc);
            lat_q.push_back(ref_lat(op, i, s));
         end
         cyc++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rand_lost_beats: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      opcode     = 6'h00;
      irq        = 1'b0;
      supervisor = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_addc();
      test_muldiv();
      test_illop();
      test_irq();
      test_backpressure();
      test_reset_mid_multi();
      test_random(600);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
